// File: rtl/rv32i_lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
package rv32i_lsu_pkg;

    typedef enum logic [1:0] {
        BYTE   = 2'b00,
        HALF   = 2'b01,
        WORD   = 2'b10,
        DOUBLE = 2'b11
    } width_e;

    typedef enum logic [2:0] {
        IDLE,
        BEAT0,
        BEAT1,
        WAIT,
        RESP
    } lsu_state_e;

    // Byte-lane mask for one access of the given width, lane 0 aligned.
    // 16 bits covers the 2*NB lane window for XLEN=64; callers truncate.
    function automatic logic [15:0] size_mask(input width_e w);
        case (w)
            BYTE:    return 16'h0001;
            HALF:    return 16'h0003;
            WORD:    return 16'h000F;
            default: return 16'h00FF;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_lsu_lane_align.sv
// Lane alignment for the load/store unit: positions store data and byte
// enables across a two-word lane window, and merges/shifts/extends the two
// read words of a load back into a right-aligned result.
module rv32i_lsu_lane_align
    import rv32i_lsu_pkg::*;
#(
    parameter  int unsigned XLEN = 32,
    localparam int unsigned NB   = XLEN / 8,
    localparam int unsigned OFS  = $clog2(NB)
) (
    input  width_e              width,
    input  logic                is_unsigned,
    input  logic [OFS-1:0]      off,
    input  logic [XLEN-1:0]     wdata,
    input  logic [XLEN-1:0]     lo,
    input  logic [XLEN-1:0]     hi,
    output logic [2*NB-1:0]     be2,
    output logic [2*XLEN-1:0]   wdata2,
    output logic [XLEN-1:0]     rdata
);

    logic [XLEN-1:0] merged;
    logic [XLEN-1:0] keep;
    logic            sign;
    int unsigned     nbits;

    // Store side: shift mask and data into the two-word window by the byte offset
    always_comb begin
        be2    = (2*NB)'(size_mask(width)) << off;
        wdata2 = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
    end

    // Load side: bring the addressed bytes down to lane 0, then extend
    always_comb begin
        merged = XLEN'({hi, lo} >> {off, 3'b000});
        nbits  = 32'd8 << width;
        keep   = '1;
        if (nbits < XLEN) begin
            keep = (XLEN'(1) << nbits) - XLEN'(1);
        end
        case (width)
            BYTE:    sign = merged[7];
            HALF:    sign = merged[15];
            WORD:    sign = merged[31];
            default: sign = merged[XLEN-1];
        endcase
        sign  = sign & ~is_unsigned;
        rdata = (merged & keep) | ({XLEN{sign}} & ~keep);
    end

endmodule

// File: rtl/rv32i_load_store_unit.sv
// Sequential load/store unit between the execute stage and a synchronous
// single-cycle-read RAM data port. Misaligned accesses that cross a RAM word
// are issued as two beats and merged on the way back.
module rv32i_load_store_unit
    import rv32i_lsu_pkg::*;
#(
    parameter  int unsigned XLEN        = 32,
    parameter  int unsigned RAM_AW      = 30,
    parameter  int unsigned MISALIGN_EN = 1,
    localparam int unsigned NB          = XLEN / 8,
    localparam int unsigned OFS         = $clog2(NB)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_width,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [NB-1:0]     ram_be,
    output logic [XLEN-1:0]   ram_wdata,
    input  logic [XLEN-1:0]   ram_rdata
);

    localparam int unsigned ADDR_BITS = RAM_AW + OFS;

    lsu_state_e state, state_next;

    logic              we_q, uns_q, split_q, err_q;
    width_e            width_q;
    logic [RAM_AW-1:0] word_q;
    logic [OFS-1:0]    off_q;
    logic [XLEN-1:0]   wdata_q, lo_q, hi_q;

    logic              accept, req_split, req_fault;
    width_e            req_w;
    logic [31:0]       split_sum;

    logic [2*NB-1:0]   be2;
    logic [2*XLEN-1:0] wdata2;
    logic [XLEN-1:0]   load_data;

    rv32i_lsu_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .width       (width_q),
        .is_unsigned (uns_q),
        .off         (off_q),
        .wdata       (wdata_q),
        .lo          (lo_q),
        .hi          (hi_q),
        .be2         (be2),
        .wdata2      (wdata2),
        .rdata       (load_data)
    );

    // Request decode: does the incoming access cross a word, and must it fault
    always_comb begin
        req_w     = width_e'(req_width);
        accept    = req_valid && (state == IDLE);
        split_sum = 32'(req_addr[OFS-1:0]) + (32'd1 << req_width);
        req_split = split_sum > NB;
        req_fault = ((req_w == DOUBLE) && (XLEN == 32))
                 || (|(req_addr >> ADDR_BITS))
                 || (req_split && (MISALIGN_EN == 0));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = req_fault ? RESP : BEAT0;
            BEAT0:   state_next = split_q ? BEAT1 : (we_q ? RESP : WAIT);
            BEAT1:   state_next = we_q ? RESP : WAIT;
            WAIT:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch and read-data capture (lo from beat 0, hi from beat 1)
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            width_q <= BYTE;
            word_q  <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                split_q <= req_split;
                err_q   <= req_fault;
                width_q <= req_w;
                word_q  <= RAM_AW'(req_addr >> OFS);
                off_q   <= req_addr[OFS-1:0];
                wdata_q <= req_wdata;
            end
            if ((state == BEAT1) && !we_q) begin
                lo_q <= ram_rdata;
            end
            if (state == WAIT) begin
                if (split_q) begin
                    hi_q <= ram_rdata;
                end else begin
                    lo_q <= ram_rdata;
                end
            end
        end
    end

    // Outputs decoded from state and the latched request
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) && err_q;
        resp_rdata = '0;
        ram_addr   = '0;
        ram_we     = 1'b0;
        ram_be     = '0;
        ram_wdata  = '0;
        case (state)
            BEAT0: begin
                ram_addr = word_q;
                if (we_q) begin
                    ram_we    = 1'b1;
                    ram_be    = be2[NB-1:0];
                    ram_wdata = wdata2[XLEN-1:0];
                end
            end
            BEAT1: begin
                ram_addr = word_q + RAM_AW'(1);
                if (we_q) begin
                    ram_we    = 1'b1;
                    ram_be    = be2[2*NB-1:NB];
                    ram_wdata = wdata2[2*XLEN-1:XLEN];
                end
            end
            RESP: begin
                if (!err_q && !we_q) begin
                    resp_rdata = load_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// Testbench for rv32i_load_store_unit (XLEN=32, small RAM so that the
// out-of-range and top-of-memory wrap cases are reachable with 32-bit addresses).
module tb_rv32i_load_store_unit;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RAM_AW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_valid, req_valid2, req_we, req_unsigned;
    logic [1:0]  req_width;
    logic [31:0] req_addr, req_wdata;

    logic              req_ready, resp_valid, resp_err, ram_we;
    logic [31:0]       resp_rdata, ram_wdata, ram_rdata;
    logic [RAM_AW-1:0] ram_addr;
    logic [3:0]        ram_be;

    logic              req_ready_n, resp_valid_n, resp_err_n, ram_we_n;
    logic [31:0]       resp_rdata_n, ram_wdata_n;
    logic [31:0]       ram_rdata_n = '0;
    logic [RAM_AW-1:0] ram_addr_n;
    logic [3:0]        ram_be_n;

    rv32i_load_store_unit #(.XLEN(XLEN), .RAM_AW(RAM_AW), .MISALIGN_EN(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_width(req_width), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_be(ram_be), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    rv32i_load_store_unit #(.XLEN(XLEN), .RAM_AW(RAM_AW), .MISALIGN_EN(0)) dut_nomis (
        .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready_n),
        .req_we(req_we), .req_width(req_width), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_n),
        .resp_err(resp_err_n), .resp_rdata(resp_rdata_n), .ram_addr(ram_addr_n),
        .ram_we(ram_we_n), .ram_be(ram_be_n), .ram_wdata(ram_wdata_n), .ram_rdata(ram_rdata_n)
    );

    // RAM model: byte-lane writes, registered one-cycle read
    logic [31:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic        we;
        logic [1:0]  width;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int unsigned exp_lat;
        int unsigned n_wr;
        logic [7:0]  a0; logic [3:0] b0; logic [31:0] d0;
        logic [7:0]  a1; logic [3:0] b1; logic [31:0] d1;
    } vec_t;

    typedef struct { logic err; logic [31:0] rdata; int unsigned lat; } exp_t;
    typedef struct { logic [7:0] addr; logic [3:0] be; logic [31:0] data; } wr_t;

    exp_t        sb[$];
    wr_t         wlog[$];
    vec_t        vecs[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    int unsigned accept_cyc = 0;
    int unsigned vidx = 0;
    int unsigned be_leak = 0;
    int unsigned we2_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response scoreboard and RAM-port monitor
    always @(negedge clk) begin
        exp_t e;
        if (!reset && resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d_err", vidx), 32'(resp_err), 32'(e.err));
                check($sformatf("v%0d_rdata", vidx), resp_rdata, e.rdata);
                check($sformatf("v%0d_latency", vidx), cyc + 1 - accept_cyc, e.lat);
            end
        end
        if (!reset && ram_we) wlog.push_back('{ram_addr, ram_be, ram_wdata});
        if (!ram_we && ram_be != '0) be_leak++;
        if (ram_we_n) we2_seen++;
    end

    function automatic vec_t mk(input logic we, input logic [1:0] w, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic err, input logic [31:0] rd, input int unsigned lat,
                                input int unsigned n,
                                input logic [7:0] a0, input logic [3:0] b0, input logic [31:0] d0,
                                input logic [7:0] a1, input logic [3:0] b1, input logic [31:0] d1);
        vec_t v;
        v.we = we; v.width = w; v.uns = uns; v.addr = a; v.wdata = wd;
        v.exp_err = err; v.exp_rdata = rd; v.exp_lat = lat; v.n_wr = n;
        v.a0 = a0; v.b0 = b0; v.d0 = d0; v.a1 = a1; v.b1 = b1; v.d1 = d1;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int unsigned idx);
        exp_t e;
        wr_t  ew [2];
        @(negedge clk);
        wlog.delete();
        vidx = idx;
        req_we = v.we; req_width = v.width; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        e.err = v.exp_err; e.rdata = v.exp_rdata; e.lat = v.exp_lat;
        sb.push_back(e);
        check($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        accept_cyc = cyc;
        req_valid = 1'b0;
        for (int k = 0; k < 12 && sb.size() != 0; k++) begin
            @(negedge clk); #1;
        end
        check($sformatf("v%0d_resp_timeout", idx), sb.size(), 32'd0);
        sb.delete();
        ew[0] = '{v.a0, v.b0, v.d0};
        ew[1] = '{v.a1, v.b1, v.d1};
        check($sformatf("v%0d_nwrites", idx), wlog.size(), v.n_wr);
        for (int k = 0; k < int'(v.n_wr) && k < wlog.size(); k++) begin
            check($sformatf("v%0d_w%0d_addr", idx, k), 32'(wlog[k].addr), 32'(ew[k].addr));
            check($sformatf("v%0d_w%0d_be", idx, k), 32'(wlog[k].be), 32'(ew[k].be));
            check($sformatf("v%0d_w%0d_data", idx, k), wlog[k].data, ew[k].data);
        end
    endtask

    task automatic req_nomis(input logic we, input logic [1:0] w, input logic [31:0] a,
                             input logic exp_err, input int unsigned exp_lat, input string tag);
        int unsigned acc, lat;
        logic        got, err;
        logic [31:0] rd;
        @(negedge clk);
        req_we = we; req_width = w; req_unsigned = 1'b0;
        req_addr = a; req_wdata = 32'hDEADBEEF; req_valid2 = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        req_valid2 = 1'b0;
        got = 1'b0; lat = 0; err = 1'b0; rd = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (resp_valid_n) begin
                got = 1'b1; lat = cyc + 1 - acc; err = resp_err_n; rd = resp_rdata_n;
                break;
            end
        end
        check({tag, "_resp_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_rdata"}, rd, 32'd0);
    endtask

    initial begin
        int unsigned stray;
        reset = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0;
        req_we = 1'b0; req_width = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_be", 32'(ram_be), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);

        //                 we    w      uns   addr          wdata         err   rdata         lat n  a0     b0     d0            a1     b1     d1
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_0050, 32'h0000_0080, 1'b0, 32'h0000_0000, 2, 1, 8'h14, 4'h1, 32'h0000_0080, 8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0050, 32'h0,         1'b0, 32'h0000_0080, 3, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0050, 32'h0,         1'b0, 32'hFFFF_FF80, 3, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h0000_0062, 32'h0000_FFFB, 1'b0, 32'h0000_0000, 2, 1, 8'h18, 4'hC, 32'hFFFB_0000, 8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0062, 32'h0,         1'b0, 32'hFFFF_FFFB, 3, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0062, 32'h0,         1'b0, 32'h0000_FFFB, 3, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0061, 32'h1234_5678, 1'b0, 32'h0000_0000, 3, 2, 8'h18, 4'hE, 32'h3456_7800, 8'h19, 4'h1, 32'h0000_0012));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0061, 32'h0,         1'b0, 32'h1234_5678, 4, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0064, 32'h0,         1'b0, 32'h0000_0012, 3, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0063, 32'h0,         1'b0, 32'h0000_1234, 4, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0063, 32'h0,         1'b0, 32'h0000_0034, 3, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h0000_0053, 32'h0000_BEEF, 1'b0, 32'h0000_0000, 3, 2, 8'h14, 4'h8, 32'hEF00_0000, 8'h15, 4'h1, 32'h0000_00BE));
        vecs.push_back(mk(1'b0, 2'b10, 1'b1, 32'h0000_0050, 32'h0,         1'b0, 32'hEF00_0080, 3, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0053, 32'h0,         1'b0, 32'hFFFF_BEEF, 4, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0070, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 2, 1, 8'h1C, 4'hF, 32'hCAFE_F00D, 8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0070, 32'h0,         1'b0, 32'hCAFE_F00D, 3, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0000, 1, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h5555_AAAA, 1'b1, 32'h0000_0000, 1, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0000_0000, 1, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_03FF, 32'hA1B2_C3D4, 1'b0, 32'h0000_0000, 3, 2, 8'hFF, 4'h8, 32'hD400_0000, 8'h00, 4'h7, 32'h00A1_B2C3));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_03FF, 32'h0,         1'b0, 32'hA1B2_C3D4, 4, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_00C3, 3, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_03FF, 32'h0000_005A, 1'b0, 32'h0000_0000, 2, 1, 8'hFF, 4'h8, 32'h5A00_0000, 8'h00, 4'h0, 32'h0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_03FF, 32'h0,         1'b0, 32'h0000_C35A, 4, 0, 8'h00, 4'h0, 32'h0,         8'h00, 4'h0, 32'h0));

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset during beat 1 of a split load aborts without a response
        @(negedge clk);
        req_we = 1'b0; req_width = 2'b10; req_unsigned = 1'b0; req_addr = 32'h0000_0061;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_beat1_addr", 32'(ram_addr), 32'h19);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) stray++;
        end
        check("abort_no_resp", stray, 32'd0);

        // Unit built without misaligned support
        req_nomis(1'b0, 2'b10, 32'h0000_0062, 1'b1, 1, "nomis_split_load");
        req_nomis(1'b1, 2'b10, 32'h0000_0063, 1'b1, 1, "nomis_split_store");
        req_nomis(1'b0, 2'b10, 32'h0000_0060, 1'b0, 3, "nomis_aligned_load");
        check("nomis_ram_we_never", we2_seen, 32'd0);
        check("be_only_with_we", be_leak, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
